// File: rtl/eeg_adc_frame_capture_if.sv
// Bus bundle between the EEG ADC frame capture block and its environment.
// master: the side that owns the ADC pins and consumes the frame.
// slave:  the capture block itself.
interface eeg_adc_frame_capture_if #(
    parameter int N_CH = 8,
    parameter int BITS = 24
);
    logic                   enable;
    logic                   adc_drdy_n;
    logic                   adc_dout;
    logic                   adc_sclk;
    logic                   adc_cs_n;
    logic [N_CH*BITS-1:0]   raw_eeg_array;
    logic                   data_valid;
    logic                   busy;
    logic [7:0]             overrun_cnt;

    modport master (
        output enable, adc_drdy_n, adc_dout,
        input  adc_sclk, adc_cs_n, raw_eeg_array, data_valid, busy, overrun_cnt
    );

    modport slave (
        input  enable, adc_drdy_n, adc_dout,
        output adc_sclk, adc_cs_n, raw_eeg_array, data_valid, busy, overrun_cnt
    );
endinterface

// File: rtl/eeg_adc_frame_capture.sv
// Serial front-end for the 8-channel EEG ADC: on each data-ready falling edge
// it clocks out one SPI-style frame of N_CH x BITS bits, publishes the packed
// frame with a one-cycle valid strobe and counts data-ready events missed
// while a frame is in flight.
module eeg_adc_frame_capture #(
    parameter int CLK_DIV = 4,
    parameter int N_CH    = 8,
    parameter int BITS    = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    eeg_adc_frame_capture_if.slave  bus
);
    localparam int         FRAME_BITS = N_CH * BITS;
    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] BIT_LAST   = 8'(FRAME_BITS - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync1_d;
    logic                   sync2_q, sync2_d;
    logic                   drdy_prev_q, drdy_prev_d;
    logic                   dout_q, dout_d;
    logic [7:0]             div_q, div_d;
    logic [7:0]             bit_cnt_q, bit_cnt_d;
    logic                   sclk_q, sclk_d;
    logic                   cs_n_q, cs_n_d;
    logic [FRAME_BITS-1:0]  shreg_q, shreg_d;
    logic [FRAME_BITS-1:0]  raw_q, raw_d;
    logic                   valid_q, valid_d;
    logic [7:0]             ovr_q, ovr_d;
    logic                   drdy_fall;

    // The shift register holds the stream in arrival order (first bit at the
    // top). Channel k arrived as the k-th word, so it sits in word N_CH-1-k;
    // reversing the word order puts channel k at [k*BITS +: BITS].
    function automatic logic [FRAME_BITS-1:0] unpack_stream(input logic [FRAME_BITS-1:0] s);
        logic [FRAME_BITS-1:0] r;
        r = '0;
        for (int k = 0; k < N_CH; k++) begin
            r[k*BITS +: BITS] = s[(N_CH-1-k)*BITS +: BITS];
        end
        return r;
    endfunction

    // State register, synchronizers and all datapath flops.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            drdy_prev_q <= 1'b1;
            dout_q      <= 1'b0;
            div_q       <= '0;
            bit_cnt_q   <= '0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            shreg_q     <= '0;
            raw_q       <= '0;
            valid_q     <= 1'b0;
            ovr_q       <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            drdy_prev_q <= drdy_prev_d;
            dout_q      <= dout_d;
            div_q       <= div_d;
            bit_cnt_q   <= bit_cnt_d;
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            shreg_q     <= shreg_d;
            raw_q       <= raw_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
        end
    end

    // Next-state logic: input conditioning, frame sequencing and overrun count.
    // NOTE: every signal gets a default first so no path leaves one unassigned
    // (which would infer a latch).
    always_comb begin
        sync1_d     = bus.adc_drdy_n;
        sync2_d     = sync1_q;
        drdy_prev_d = sync2_q;
        dout_d      = bus.adc_dout;
        drdy_fall   = drdy_prev_q & ~sync2_q;

        state_d   = state_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        shreg_d   = shreg_q;
        raw_d     = raw_q;
        valid_d   = 1'b0;
        ovr_d     = ovr_q;

        // A data-ready edge while a frame is running is lost; count it,
        // saturating so the counter never wraps back to a small value.
        if (drdy_fall && (state_q != IDLE) && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (drdy_fall && bus.enable) begin
                    state_d = SETUP;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    div_d   = '0;
                end
            end
            SETUP: begin
                if (div_q == DIV_LAST) begin
                    state_d   = SHIFT;
                    div_d     = '0;
                    bit_cnt_d = '0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d = '0;
                    if (!sclk_q) begin
                        // End of low phase: rising sclk edge captures the bit.
                        sclk_d  = 1'b1;
                        shreg_d = {shreg_q[FRAME_BITS-2:0], dout_q};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = HOLD;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 8'd1;
                        end
                    end
                end
            end
            HOLD: begin
                if (div_q == DIV_LAST) begin
                    state_d = IDLE;
                    cs_n_d  = 1'b1;
                    div_d   = '0;
                    raw_d   = unpack_stream(shreg_q);
                    valid_d = 1'b1;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
            end
        endcase
    end

    assign bus.adc_sclk      = sclk_q;
    assign bus.adc_cs_n      = cs_n_q;
    assign bus.raw_eeg_array = raw_q;
    assign bus.data_valid    = valid_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.overrun_cnt   = ovr_q;
endmodule

// File: tb/tb_eeg_adc_frame_capture.sv
// Self-checking bench for eeg_adc_frame_capture. Two instances (CLK_DIV=4 and
// CLK_DIV=2) share stimulus; `sel` picks which one is driven and observed.
// An ADC model serves the transmitted stream bit-by-bit on sclk; expected
// frames come from the channel words directly.
module tb_eeg_adc_frame_capture;
    localparam int N_CH = 8;
    localparam int BITS = 24;
    localparam int FB   = N_CH * BITS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic sel;
    logic enable;
    logic drdy_n;
    logic dout;

    eeg_adc_frame_capture_if #(.N_CH(N_CH), .BITS(BITS)) bus4 ();
    eeg_adc_frame_capture_if #(.N_CH(N_CH), .BITS(BITS)) bus2 ();

    eeg_adc_frame_capture #(.CLK_DIV(4), .N_CH(N_CH), .BITS(BITS)) dut4 (
        .clk (clk), .rst (rst), .bus (bus4));
    eeg_adc_frame_capture #(.CLK_DIV(2), .N_CH(N_CH), .BITS(BITS)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2));

    assign bus4.enable     = enable;
    assign bus4.adc_drdy_n = sel ? 1'b1 : drdy_n;
    assign bus4.adc_dout   = dout;
    assign bus2.enable     = enable;
    assign bus2.adc_drdy_n = sel ? drdy_n : 1'b1;
    assign bus2.adc_dout   = dout;

    logic          obs_sclk, obs_cs_n, obs_valid, obs_busy;
    logic [FB-1:0] obs_raw;
    logic [7:0]    obs_ovr;
    assign obs_sclk  = sel ? bus2.adc_sclk      : bus4.adc_sclk;
    assign obs_cs_n  = sel ? bus2.adc_cs_n      : bus4.adc_cs_n;
    assign obs_valid = sel ? bus2.data_valid    : bus4.data_valid;
    assign obs_busy  = sel ? bus2.busy          : bus4.busy;
    assign obs_raw   = sel ? bus2.raw_eeg_array : bus4.raw_eeg_array;
    assign obs_ovr   = sel ? bus2.overrun_cnt   : bus4.overrun_cnt;

    int cur_div;
    always_comb cur_div = sel ? 2 : 4;

    int checks = 0;
    int errors = 0;
    int exp_ovr = 0;

    // Reference model: channel words and the serial stream they produce.
    logic [BITS-1:0] ch_words [N_CH];
    logic [FB-1:0]   tx_stream;

    task automatic set_words();
        for (int i = 0; i < FB; i++) begin
            tx_stream[i] = ch_words[i / BITS][BITS - 1 - (i % BITS)];
        end
    endtask

    function automatic logic [FB-1:0] model_frame();
        logic [FB-1:0] f;
        for (int k = 0; k < N_CH; k++) f[k*BITS +: BITS] = ch_words[k];
        return f;
    endfunction

    // Monitor: cycle counts and sclk shape (period, high time, idle-low).
    int   cyc = 0, n_cs_low = 0, n_valid = 0, n_rise = 0, n_bad = 0;
    int   last_rise = 0, hi_len = 0;
    logic have_rise = 1'b0;
    logic prev_sclk = 1'b0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!obs_cs_n) n_cs_low <= n_cs_low + 1;
        if (obs_valid) n_valid <= n_valid + 1;
        if (obs_sclk && !prev_sclk) begin
            n_rise    <= n_rise + 1;
            last_rise <= cyc;
            have_rise <= 1'b1;
            if (have_rise && !obs_cs_n && (cyc - last_rise != 2 * cur_div)) n_bad <= n_bad + 1;
        end
        if (obs_sclk) hi_len <= hi_len + 1;
        else hi_len <= 0;
        if (!obs_sclk && prev_sclk && hi_len != cur_div) n_bad <= n_bad + 1;
        if (obs_sclk && obs_cs_n) n_bad <= n_bad + 1;
        if (obs_cs_n) have_rise <= 1'b0;
        prev_sclk <= obs_sclk;
    end

    // ADC model: presents stream bit i after the i-th sclk rise of the frame.
    int bit_idx = 0;
    always @(negedge clk) begin
        if (obs_cs_n) begin
            bit_idx <= 0;
            dout    <= tx_stream[0];
        end else if (obs_sclk && !prev_sclk) begin
            bit_idx <= bit_idx + 1;
            dout    <= (bit_idx + 1 < FB) ? tx_stream[bit_idx + 1] : 1'b0;
        end
    end

    task automatic pulse_drdy();
        drdy_n = 1'b0;
        repeat (4) @(negedge clk);
        drdy_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_valid(input string name, output bit ok);
        int budget;
        budget = cur_div * (2 * FB + 2) + 60;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (obs_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s timeout: data_valid not seen within %0d cycles", name, budget);
        end
    endtask

    // Runs one frame of the current ch_words and checks data plus timing.
    task automatic run_frame(input string name);
        int s_rise, s_cs, s_val, s_bad;
        bit ok;
        logic [FB-1:0] exp_f;
        set_words();
        exp_f  = model_frame();
        s_rise = n_rise; s_cs = n_cs_low; s_val = n_valid; s_bad = n_bad;
        pulse_drdy();
        wait_valid(name, ok);
        checks++;
        if (obs_raw !== exp_f) begin
            errors++;
            $display("FAIL %s data: got %h expected %h", name, obs_raw, exp_f);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (n_rise - s_rise !== FB) begin
            errors++;
            $display("FAIL %s sclk_rises: got %0d expected %0d", name, n_rise - s_rise, FB);
        end
        checks++;
        if (n_cs_low - s_cs !== cur_div * (2 + 2 * FB)) begin
            errors++;
            $display("FAIL %s cs_low_cycles: got %0d expected %0d", name, n_cs_low - s_cs, cur_div * (2 + 2 * FB));
        end
        checks++;
        if (n_valid - s_val !== 1) begin
            errors++;
            $display("FAIL %s valid_cycles: got %0d expected 1", name, n_valid - s_val);
        end
        checks++;
        if (n_bad - s_bad !== 0) begin
            errors++;
            $display("FAIL %s sclk_shape: got %0d bad phases expected 0", name, n_bad - s_bad);
        end
        checks++;
        if (obs_cs_n !== 1'b1 || obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: got cs_n=%b busy=%b expected cs_n=1 busy=0", name, obs_cs_n, obs_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sel = 1'b0; enable = 1'b1; drdy_n = 1'b1;
        for (int k = 0; k < N_CH; k++) ch_words[k] = '0;
        set_words();
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs_sclk !== 1'b0 || obs_cs_n !== 1'b1 || obs_valid !== 1'b0 || obs_busy !== 1'b0
            || obs_raw !== '0 || obs_ovr !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got sclk=%b cs_n=%b valid=%b busy=%b ovr=%0d raw=%h expected 0 1 0 0 0 0",
                     obs_sclk, obs_cs_n, obs_valid, obs_busy, obs_ovr, obs_raw);
        end
    endtask

    task automatic test_single_frame();
        for (int k = 0; k < N_CH; k++) ch_words[k] = 24'hA00000 + 24'(k);
        run_frame("single_frame");
        checks++;
        if (obs_raw[23:0] !== 24'hA00000 || obs_raw[191:168] !== 24'hA00007) begin
            errors++;
            $display("FAIL single_frame_slices: got ch0=%h ch7=%h expected a00000 a00007", obs_raw[23:0], obs_raw[191:168]);
        end
    endtask

    task automatic test_bit_order();
        logic [FB-1:0] want;
        int s_val;
        for (int k = 0; k < N_CH; k++) ch_words[k] = '0;
        ch_words[0] = 24'h800001;
        run_frame("bit_order");
        want = '0; want[23] = 1'b1; want[0] = 1'b1;
        checks++;
        if (obs_raw !== want) begin
            errors++;
            $display("FAIL bit_order_bits: got %h expected %h", obs_raw, want);
        end
        for (int k = 0; k < N_CH; k++) ch_words[k] = 24'hFFFFFF;
        run_frame("all_ones");
        s_val = n_valid;
        repeat (200) @(negedge clk);
        checks++;
        if (obs_raw !== {FB{1'b1}} || n_valid != s_val) begin
            errors++;
            $display("FAIL hold_between_strobes: got %h strobes=%0d expected all ones, 0 strobes", obs_raw, n_valid - s_val);
        end
    endtask

    task automatic test_random_frames();
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < N_CH; k++) ch_words[k] = 24'($urandom);
            run_frame("random_frame");
        end
    endtask

    task automatic test_enable();
        int s_cs;
        bit ok;
        logic [FB-1:0] exp_f;
        enable = 1'b0;
        s_cs = n_cs_low;
        pulse_drdy();
        repeat (40) @(negedge clk);
        checks++;
        if (n_cs_low != s_cs || obs_ovr !== 8'(exp_ovr) || obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL enable_gate: got cs_low=%0d ovr=%0d busy=%b expected 0 %0d 0", n_cs_low - s_cs, obs_ovr, obs_busy, exp_ovr);
        end
        enable = 1'b1;
        for (int k = 0; k < N_CH; k++) ch_words[k] = 24'($urandom);
        set_words();
        exp_f = model_frame();
        pulse_drdy();
        repeat (100) @(negedge clk);
        enable = 1'b0;
        checks++;
        if (obs_busy !== 1'b1) begin
            errors++;
            $display("FAIL enable_midframe_busy: got %b expected 1", obs_busy);
        end
        wait_valid("enable_midframe", ok);
        checks++;
        if (obs_raw !== exp_f) begin
            errors++;
            $display("FAIL enable_midframe_data: got %h expected %h", obs_raw, exp_f);
        end
        repeat (5) @(negedge clk);
        s_cs = n_cs_low;
        pulse_drdy();
        repeat (40) @(negedge clk);
        checks++;
        if (n_cs_low != s_cs || obs_ovr !== 8'(exp_ovr)) begin
            errors++;
            $display("FAIL enable_after_drop: got cs_low=%0d ovr=%0d expected 0 %0d", n_cs_low - s_cs, obs_ovr, exp_ovr);
        end
        enable = 1'b1;
    endtask

    task automatic test_overrun();
        bit ok;
        logic [FB-1:0] exp_f;
        for (int k = 0; k < N_CH; k++) ch_words[k] = 24'($urandom);
        set_words();
        exp_f = model_frame();
        pulse_drdy();
        for (int p = 0; p < 3; p++) begin
            repeat (50) @(negedge clk);
            pulse_drdy();
        end
        exp_ovr = (exp_ovr + 3 > 255) ? 255 : exp_ovr + 3;
        wait_valid("overrun3", ok);
        checks++;
        if (obs_raw !== exp_f) begin
            errors++;
            $display("FAIL overrun3_data: got %h expected %h", obs_raw, exp_f);
        end
        checks++;
        if (obs_ovr !== 8'(exp_ovr)) begin
            errors++;
            $display("FAIL overrun3_count: got %0d expected %0d", obs_ovr, exp_ovr);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_overrun_saturate();
        bit idle;
        for (int p = 0; p < 300; p++) pulse_drdy();
        idle = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!obs_busy) begin
                idle = 1'b1;
                break;
            end
        end
        exp_ovr = 255;
        checks++;
        if (!idle || obs_ovr !== 8'(exp_ovr)) begin
            errors++;
            $display("FAIL overrun_saturate: got ovr=%0d idle=%b expected 255 1", obs_ovr, idle);
        end
    endtask

    task automatic test_reset_midframe();
        int s_rise;
        bit reached;
        for (int k = 0; k < N_CH; k++) ch_words[k] = 24'($urandom);
        set_words();
        s_rise = n_rise;
        pulse_drdy();
        reached = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (n_rise - s_rise >= 100) begin
                reached = 1'b1;
                break;
            end
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL reset_mid_reach: got %0d rises expected 100", n_rise - s_rise);
        end
        rst = 1'b1;
        #1;
        exp_ovr = 0;
        checks++;
        if (obs_sclk !== 1'b0 || obs_cs_n !== 1'b1 || obs_busy !== 1'b0 || obs_raw !== '0
            || obs_valid !== 1'b0 || obs_ovr !== 8'd0) begin
            errors++;
            $display("FAIL reset_midframe: got sclk=%b cs_n=%b busy=%b valid=%b ovr=%0d raw=%h expected 0 1 0 0 0 0",
                     obs_sclk, obs_cs_n, obs_busy, obs_valid, obs_ovr, obs_raw);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < N_CH; k++) ch_words[k] = 24'($urandom);
        run_frame("after_reset");
    endtask

    task automatic test_clk_div2();
        sel = 1'b1;
        repeat (4) @(negedge clk);
        for (int k = 0; k < N_CH; k++) ch_words[k] = 24'hA00000 + 24'(k);
        run_frame("clk_div2");
        for (int k = 0; k < N_CH; k++) ch_words[k] = 24'($urandom);
        run_frame("clk_div2_random");
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_bit_order();
        test_random_frames();
        test_enable();
        test_overrun();
        test_overrun_saturate();
        test_reset_midframe();
        test_clk_div2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
